// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types and response codes for the register-slave slice.
package axil_pkg;

    typedef logic [1:0] axil_resp_t;
    typedef logic [2:0] axil_prot_t;

    localparam axil_resp_t RESP_OKAY   = 2'b00;
    localparam axil_resp_t RESP_SLVERR = 2'b10;
    localparam axil_resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle; master drives requests, slave drives responses.
interface axil_reg_slave_if
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);

    logic [ADDR_WIDTH-1:0] awaddr;
    axil_prot_t            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;

    axil_resp_t            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ADDR_WIDTH-1:0] araddr;
    axil_prot_t            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    axil_resp_t            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axil_hold_reg.sv
// One-entry valid/ready holding buffer; a pop and a push in the same cycle
// replace the entry so the channel can stream at one beat per cycle.
module axil_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             pop_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q;
    logic             full_d;
    logic             push;
    logic [WIDTH-1:0] data_q;

    assign ready_o = en_i && (!full_q || pop_i);
    assign push    = valid_i && ready_o;

    always_comb begin
        full_d = full_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (push) begin
            full_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // Payload needs no reset: it is only consumed while full_q is set.
    always_ff @(posedge aclk) begin
        if (push) begin
            data_q <= data_i;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register file endpoint: NUM_REGS 32-bit registers, byte strobes,
// independent AW/W acceptance and DECERR for addresses outside the window.
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    axil_reg_slave_if.slave                s_axil,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic                                 ready_en_q;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_q;
    logic [NUM_REGS-1:0]                  pulse_q;

    logic                  aw_full;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic                  w_full;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  commit;
    logic                  hold_en;

    logic [ADDR_WIDTH-1:0] aw_off;
    logic [ADDR_WIDTH-1:0] ar_off;
    logic                  aw_hit;
    logic                  ar_hit;
    logic [IDX_W-1:0]      aw_idx;
    logic [IDX_W-1:0]      ar_idx;

    logic                  bvalid_q, bvalid_d;
    axil_resp_t            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    axil_resp_t            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ar_hs;

    // Keeps readies low until the first edge seen out of reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    assign hold_en = aresetn && ready_en_q;
    assign commit  = aw_full && w_full && (!bvalid_q || s_axil.bready);

    axil_hold_reg #(
        .WIDTH (ADDR_WIDTH)
    ) u_aw_hold (
        .aclk    (aclk),
        .aresetn (aresetn),
        .en_i    (hold_en),
        .data_i  (s_axil.awaddr),
        .valid_i (s_axil.awvalid),
        .ready_o (s_axil.awready),
        .pop_i   (commit),
        .full_o  (aw_full),
        .data_o  (aw_addr)
    );

    axil_hold_reg #(
        .WIDTH (STRB_WIDTH + DATA_WIDTH)
    ) u_w_hold (
        .aclk    (aclk),
        .aresetn (aresetn),
        .en_i    (hold_en),
        .data_i  ({s_axil.wstrb, s_axil.wdata}),
        .valid_i (s_axil.wvalid),
        .ready_o (s_axil.wready),
        .pop_i   (commit),
        .full_o  (w_full),
        .data_o  ({w_strb, w_data})
    );

    // Window decode: byte offset from BASE_ADDR, word index above bit 1.
    assign aw_off = aw_addr - BASE_ADDR;
    assign ar_off = s_axil.araddr - BASE_ADDR;
    assign aw_hit = (aw_addr >= BASE_ADDR) && (aw_off[ADDR_WIDTH-1:2+IDX_W] == '0);
    assign ar_hit = (s_axil.araddr >= BASE_ADDR) && (ar_off[ADDR_WIDTH-1:2+IDX_W] == '0);
    assign aw_idx = aw_off[2 +: IDX_W];
    assign ar_idx = ar_off[2 +: IDX_W];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            regs_q  <= '0;
            pulse_q <= '0;
        end else begin
            pulse_q <= '0;
            if (commit && aw_hit) begin
                pulse_q[aw_idx] <= 1'b1;
                for (int b = 0; b < STRB_WIDTH; b++) begin
                    if (w_strb[b]) begin
                        regs_q[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (bvalid_q && s_axil.bready) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = aw_hit ? RESP_OKAY : RESP_DECERR;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
        end
    end

    // Read path never looks at the write buffers; same-edge writes are
    // invisible to the read because regs_q is sampled before update.
    assign s_axil.arready = hold_en && (!rvalid_q || s_axil.rready);
    assign ar_hs          = s_axil.arvalid && s_axil.arready;

    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (rvalid_q && s_axil.rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            if (ar_hit) begin
                rresp_d = RESP_OKAY;
                rdata_d = regs_q[ar_idx];
            end else begin
                rresp_d = RESP_DECERR;
                rdata_d = '0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

    assign s_axil.bvalid = bvalid_q;
    assign s_axil.bresp  = bresp_q;
    assign s_axil.rvalid = rvalid_q;
    assign s_axil.rresp  = rresp_q;
    assign s_axil.rdata  = rdata_q;
    assign reg_q         = regs_q;
    assign reg_wr_pulse  = pulse_q;

    logic unused_bits;
    assign unused_bits = ^{s_axil.awprot, s_axil.arprot, aw_off[1:0], ar_off[1:0]};

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: stimulus queues expected B/R beats,
// a negedge monitor pops and compares them on every handshake.
module tb_axil_reg_slave;
    import axil_pkg::*;

    localparam int NR = 16;

    logic               aclk = 1'b0;
    logic               aresetn = 1'b0;
    logic [NR*32-1:0]   reg_q;
    logic [NR-1:0]      reg_wr_pulse;

    axil_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axil_reg_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (NR),
        .BASE_ADDR  (32'h0)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axil       (bus),
        .reg_q        (reg_q),
        .reg_wr_pulse (reg_wr_pulse)
    );

    always #5 aclk = ~aclk;

    int          checks = 0;
    int          errors = 0;
    axil_resp_t  b_exp_q[$];
    logic [33:0] r_exp_q[$];
    int          aw_cnt = 0;
    int          w_cnt = 0;
    int          pulse_cnt = 0;
    axil_resp_t  b_exp;
    logic [33:0] r_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: sampled half a cycle before the edge that completes each handshake.
    always @(negedge aclk) begin
        if (!aresetn) begin
            b_exp_q.delete();
            r_exp_q.delete();
        end else begin
            if (bus.bvalid && bus.bready) begin
                if (b_exp_q.size() == 0) begin
                    chk("b_unexpected_beat", b_exp_q.size(), 1);
                end else begin
                    b_exp = b_exp_q.pop_front();
                    chk("bresp", bus.bresp, b_exp);
                end
            end
            if (bus.rvalid && bus.rready) begin
                if (r_exp_q.size() == 0) begin
                    chk("r_unexpected_beat", r_exp_q.size(), 1);
                end else begin
                    r_exp = r_exp_q.pop_front();
                    chk("rresp", bus.rresp, r_exp[33:32]);
                    chk("rdata", bus.rdata, r_exp[31:0]);
                end
            end
            if (bus.awvalid && bus.awready) aw_cnt++;
            if (bus.wvalid && bus.wready) w_cnt++;
            if (reg_wr_pulse != '0) pulse_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic aw_send(input logic [31:0] a);
        logic done;
        done = 1'b0;
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge aclk);
            if (bus.awready) done = 1'b1;
        end
        if (done) begin
            @(posedge aclk);
            #1;
        end else begin
            chk("aw_timeout", done, 1);
        end
        bus.awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s);
        logic done;
        done = 1'b0;
        bus.wdata  = d;
        bus.wstrb  = s;
        bus.wvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge aclk);
            if (bus.wready) done = 1'b1;
        end
        if (done) begin
            @(posedge aclk);
            #1;
        end else begin
            chk("w_timeout", done, 1);
        end
        bus.wvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] a);
        logic done;
        done = 1'b0;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge aclk);
            if (bus.arready) done = 1'b1;
        end
        if (done) begin
            @(posedge aclk);
            #1;
        end else begin
            chk("ar_timeout", done, 1);
        end
        bus.arvalid = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input axil_resp_t resp);
        b_exp_q.push_back(resp);
        fork
            aw_send(a);
            w_send(d, s);
        join
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input axil_resp_t resp);
        r_exp_q.push_back({resp, d});
        ar_send(a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    logic [NR*32-1:0] snap;
    logic [31:0]      stream_exp [8];
    int               a0, w0, p0;

    initial begin
        bus.awaddr = '0; bus.awprot = 3'b000; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wstrb  = '0;     bus.wvalid  = 1'b0;
        bus.araddr = '0; bus.arprot = 3'b000; bus.arvalid = 1'b0;
        bus.bready = 1'b1;
        bus.rready = 1'b1;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_awready", bus.awready, 0);
        chk("rst_wready", bus.wready, 0);
        chk("rst_arready", bus.arready, 0);
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_reg_q_zero", reg_q == '0, 1);
        chk("rst_pulse", reg_wr_pulse, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("pre_edge_awready", bus.awready, 0);
        @(negedge aclk);
        chk("post_rst_awready", bus.awready, 1);
        chk("post_rst_wready", bus.wready, 1);
        chk("post_rst_arready", bus.arready, 1);
        @(posedge aclk);
        #1;

        // Aligned write then read
        wr(32'h08, 32'hDEADBEEF, 4'hF, RESP_OKAY);
        @(negedge aclk);
        chk("wr_bvalid_early", bus.bvalid, 0);
        chk("wr_pulse_early", reg_wr_pulse, 0);
        @(negedge aclk);
        chk("wr_bvalid", bus.bvalid, 1);
        chk("wr_pulse2", reg_wr_pulse, 16'h0004);
        chk("wr_reg2", reg_q[2*32 +: 32], 32'hDEADBEEF);
        @(negedge aclk);
        chk("wr_pulse_clear", reg_wr_pulse, 0);
        @(posedge aclk);
        #1;
        rd(32'h08, 32'hDEADBEEF, RESP_OKAY);
        cyc(2);

        // W ahead of AW with partial strobes
        wr(32'h0C, 32'hFFFFFFFF, 4'hF, RESP_OKAY);
        cyc(3);
        chk("reg3_prefill", reg_q[3*32 +: 32], 32'hFFFFFFFF);
        a0 = aw_cnt;
        w0 = w_cnt;
        b_exp_q.push_back(RESP_OKAY);
        w_send(32'h11223344, 4'h5);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("w_held_wready", bus.wready, 0);
            chk("w_held_bvalid", bus.bvalid, 0);
            @(posedge aclk);
            #1;
        end
        aw_send(32'h0C);
        cyc(3);
        chk("reg3_strobed", reg_q[3*32 +: 32], 32'hFF22FF44);
        chk("aw_once", aw_cnt - a0, 1);
        chk("w_once", w_cnt - w0, 1);

        // Out of range write and read
        snap = reg_q;
        p0 = pulse_cnt;
        wr(32'h40, 32'hCAFEF00D, 4'hF, RESP_DECERR);
        cyc(4);
        chk("oor_reg_q_same", reg_q === snap, 1);
        chk("oor_no_pulse", pulse_cnt - p0, 0);
        rd(32'h40, 32'h0, RESP_DECERR);
        cyc(2);

        // B backpressure with two queued writes
        bus.bready = 1'b0;
        wr(32'h10, 32'h0000000A, 4'hF, RESP_OKAY);
        wr(32'h44, 32'h0000000B, 4'hF, RESP_DECERR);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("bp_bvalid", bus.bvalid, 1);
            chk("bp_bresp", bus.bresp, RESP_OKAY);
            chk("bp_awready", bus.awready, 0);
            chk("bp_wready", bus.wready, 0);
            @(posedge aclk);
            #1;
        end
        chk("bp_reg4", reg_q[4*32 +: 32], 32'h0000000A);
        bus.bready = 1'b1;
        cyc(4);
        chk("bp_b_drained", b_exp_q.size(), 0);

        // Streaming reads at one per cycle
        stream_exp[0] = 32'h0;
        stream_exp[1] = 32'h0;
        stream_exp[2] = 32'hDEADBEEF;
        stream_exp[3] = 32'hFF22FF44;
        stream_exp[4] = 32'h0000000A;
        stream_exp[5] = 32'h0;
        stream_exp[6] = 32'h0;
        stream_exp[7] = 32'h0;
        for (int i = 0; i < 8; i++) begin
            bus.araddr  = 32'(i * 4);
            bus.arvalid = 1'b1;
            r_exp_q.push_back({RESP_OKAY, stream_exp[i]});
            @(negedge aclk);
            chk("stream_arready", bus.arready, 1);
            if (i > 0) chk("stream_rvalid", bus.rvalid, 1);
            @(posedge aclk);
            #1;
        end
        bus.arvalid = 1'b0;
        @(negedge aclk);
        chk("stream_last_rvalid", bus.rvalid, 1);
        @(negedge aclk);
        chk("stream_idle_rvalid", bus.rvalid, 0);
        @(posedge aclk);
        #1;

        // R stall keeps payload stable
        bus.rready = 1'b0;
        rd(32'h08, 32'hDEADBEEF, RESP_OKAY);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("stall_rvalid", bus.rvalid, 1);
            chk("stall_rdata", bus.rdata, 32'hDEADBEEF);
            chk("stall_arready", bus.arready, 0);
            @(posedge aclk);
            #1;
        end
        bus.rready = 1'b1;
        cyc(2);

        // Reset in the middle of a read burst
        bus.rready = 1'b0;
        r_exp_q.push_back({RESP_OKAY, 32'h0000000A});
        ar_send(32'h10);
        bus.araddr  = 32'h14;
        bus.arvalid = 1'b1;
        @(negedge aclk);
        chk("burst_rvalid", bus.rvalid, 1);
        chk("burst_arready_stalled", bus.arready, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(negedge aclk);
        chk("midrst_arready", bus.arready, 0);
        @(posedge aclk);
        #1;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        @(negedge aclk);
        chk("midrst_rvalid", bus.rvalid, 0);
        chk("midrst_reg_q_zero", reg_q == '0, 1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        cyc(2);
        chk("midrst_r_dropped", r_exp_q.size(), 0);
        @(negedge aclk);
        chk("midrst_no_beat", bus.rvalid, 0);
        @(posedge aclk);
        #1;
        rd(32'h08, 32'h0, RESP_OKAY);
        cyc(3);
        chk("final_r_drained", r_exp_q.size(), 0);
        chk("final_b_drained", b_exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
